// File: rtl/ram_latency_ctrl_pkg.sv
// ram_pkg: shared types and constants for the latency-modelled main memory.
//   ramstate_t : encoding of the ramstate bus seen by memory_control/caches
//   fsm_t      : internal controller states
//   req_t      : snapshot of an accepted request {byte address, write flag, data}
package ram_pkg;

    localparam int ADDR_W_DEF = 14;
    // Wide enough for LAT-1 with LAT up to 15.
    localparam int CNT_W      = 4;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HIT  = 2'd2,
        BAD  = 2'd3
    } fsm_t;

    typedef struct packed {
        word_t addr;
        logic  wr;
        word_t wdata;
    } req_t;

    // Bus-visible status for each controller state.
    function automatic ramstate_t to_ramstate(input fsm_t s);
        ramstate_t r;
        case (s)
            IDLE:    r = FREE;
            WAIT:    r = BUSY;
            HIT:     r = ACCESS;
            default: r = ERROR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_latency_ctrl_array.sv
// ram_array: word-addressed storage behind ram_latency_ctrl.
//   CLK   : clock, writes on rising edge
//   nRST  : synchronous active-high reset; clears every word when INIT_ZERO=1
//   wen   : write enable (ignored while nRST is high)
//   waddr : word index to write
//   wdata : write data
//   raddr : word index to read
//   rdata : combinational read data
module ram_array
    import ram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  word_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output word_t             rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    word_t words [DEPTH];

    // One register per word so that the reset clear and the addressed write
    // live in the same process for each word.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            word_t word_reg;

            always_ff @(posedge CLK) begin
                if (nRST) begin
                    if (INIT_ZERO) begin
                        word_reg <= '0;
                    end
                end else if (wen && (waddr == ADDR_W'(gi))) begin
                    word_reg <= wdata;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rdata = words[raddr];

endmodule

// File: rtl/ram_latency_ctrl.sv
// ram_latency_ctrl: main-memory model with programmable access latency.
// A legal request held steady for LAT rising edges produces ACCESS; BUSY is
// shown before that. Illegal requests (both enables, misaligned, or beyond
// the array) show ERROR and never touch the array.
//   CLK       : clock
//   nRST      : synchronous active-high reset
//   memaddr   : byte address, word index = memaddr[ADDR_W+1:2]
//   memstore  : write data
//   memREN    : read request, held until ACCESS
//   memWEN    : write request, held until ACCESS
//   ramload   : read data, meaningful while ramstate==ACCESS for a read
//   ramstate  : FREE / BUSY / ACCESS / ERROR
// LAT must lie in 1..15.
module ram_latency_ctrl
    import ram_pkg::*;
#(
    parameter int LAT       = 2,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] memaddr,
    input  logic [31:0] memstore,
    input  logic        memREN,
    input  logic        memWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

    fsm_t             state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    req_t             snap_reg, snap_next;
    ramstate_t        ramstate_reg;
    word_t            ramload_reg;

    req_t              cur_req;
    logic              req;
    logic              illegal;
    logic              changed;
    logic              restart;
    logic              accept;
    logic              enter_hit;
    logic              wen;
    logic [ADDR_W-1:0] word_idx;
    word_t             rdata;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign req     = memREN | memWEN;
    assign illegal = (memREN & memWEN)
                   | (memaddr[1:0] != 2'b00)
                   | (memaddr[31:ADDR_W+2] != '0);

    always_comb begin
        cur_req       = '0;
        cur_req.addr  = memaddr;
        cur_req.wr    = memWEN;
        cur_req.wdata = memstore;
    end

    assign changed = (cur_req != snap_reg);
    // An illegal request can match a write snapshot in addr/type/data (both
    // enables set), so illegality also forces re-evaluation.
    assign restart = changed | illegal;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        snap_next  = snap_reg;
        accept     = 1'b0;
        enter_hit  = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (restart) begin
                    accept = 1'b1;
                end else if (cnt_reg == CNT_W'(1)) begin
                    state_next = HIT;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            HIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (restart) begin
                    accept = 1'b1;
                end
            end
            BAD: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (!illegal) begin
                    accept = 1'b1;
                end
            end
        endcase

        // Fresh evaluation of the current inputs, shared by every state.
        if (accept) begin
            if (illegal) begin
                state_next = BAD;
            end else begin
                snap_next  = cur_req;
                cnt_next   = LAT_M1;
                state_next = (LAT == 1) ? HIT : WAIT;
            end
        end

        // Entering HIT for a new snapshot; staying in HIT never re-commits.
        if (state_next == HIT && (state_reg != HIT || accept)) begin
            enter_hit = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign word_idx = snap_next.addr[ADDR_W+1:2];
    assign wen      = enter_hit & snap_next.wr & ~nRST;

    ram_array #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_array (
        .CLK   (CLK),
        .nRST  (nRST),
        .wen   (wen),
        .waddr (word_idx),
        .wdata (snap_next.wdata),
        .raddr (word_idx),
        .rdata (rdata)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            snap_reg     <= '0;
            ramstate_reg <= FREE;
            ramload_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            snap_reg     <= snap_next;
            ramstate_reg <= to_ramstate(state_next);
            // A read never coincides with a write commit, so rdata here is
            // the settled word; held reads refresh it every cycle.
            ramload_reg  <= (state_next == HIT && !snap_next.wr) ? rdata : '0;
        end
    end

    assign ramstate = ramstate_reg;
    assign ramload  = ramload_reg;

endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Bench for ram_latency_ctrl: two instances (LAT=2 and LAT=1) checked every
// cycle against a request-age model, plus literal expectations for the
// directed scenarios.
module tb_ram_latency_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_a, ren_a, wen_a, rst_b, ren_b, wen_b;
    logic [31:0] addr_a, store_a, load_a, addr_b, store_b, load_b;
    logic [1:0]  state_a, state_b;

    ram_latency_ctrl #(.LAT(2), .ADDR_W(AW), .INIT_ZERO(1'b1)) dut_a (
        .CLK(CLK), .nRST(rst_a), .memaddr(addr_a), .memstore(store_a),
        .memREN(ren_a), .memWEN(wen_a), .ramload(load_a), .ramstate(state_a)
    );

    ram_latency_ctrl #(.LAT(1), .ADDR_W(AW), .INIT_ZERO(1'b1)) dut_b (
        .CLK(CLK), .nRST(rst_b), .memaddr(addr_b), .memstore(store_b),
        .memREN(ren_b), .memWEN(wen_b), .ramload(load_b), .ramstate(state_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    // A legal request's age is the number of consecutive edges it has been
    // seen unchanged. Age < LAT -> BUSY, age >= LAT -> ACCESS; the write
    // lands on the edge where age first reaches LAT.
    logic [31:0] mem_m  [2][DEPTH];
    int          age_m  [2];
    logic [65:0] id_m   [2];
    logic [1:0]  st_m   [2];
    logic [31:0] ld_m   [2];
    bit          chk_m  [2];
    bit          live_m [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            live_m[i] = 1'b0;
            age_m[i]  = 0;
            id_m[i]   = '0;
            st_m[i]   = 2'd0;
            ld_m[i]   = '0;
            chk_m[i]  = 1'b0;
        end
    end

    task automatic model_edge(input int i, input int lat, input logic rst,
                              input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] store);
        logic [65:0] id;
        logic        bad;
        bit          fresh;
        int          prev_age;
        int          new_age;
        id       = {ren, wen, addr, store};
        bad      = (ren && wen) || (addr[1:0] != 2'b00) || (addr[31:AW+2] != 0);
        prev_age = age_m[i];
        chk_m[i] = 1'b0;
        if (rst) begin
            live_m[i] = 1'b1;
            age_m[i]  = 0;
            st_m[i]   = 2'd0;
            ld_m[i]   = '0;
            chk_m[i]  = 1'b1;
            for (int w = 0; w < DEPTH; w++) mem_m[i][w] = '0;
        end else if (!(ren || wen)) begin
            age_m[i] = 0;
            st_m[i]  = 2'd0;
            ld_m[i]  = '0;
        end else if (bad) begin
            age_m[i] = 0;
            st_m[i]  = 2'd3;
            ld_m[i]  = '0;
        end else begin
            fresh   = !(prev_age > 0 && id == id_m[i]);
            new_age = fresh ? 1 : ((prev_age < lat) ? prev_age + 1 : lat);
            age_m[i] = new_age;
            if (new_age < lat) begin
                st_m[i] = 2'd1;
                ld_m[i] = '0;
            end else begin
                st_m[i] = 2'd2;
                if (wen) begin
                    if (fresh || prev_age < lat) mem_m[i][addr[AW+1:2]] = store;
                    ld_m[i] = '0;
                end else begin
                    ld_m[i]  = mem_m[i][addr[AW+1:2]];
                    chk_m[i] = 1'b1;
                end
            end
        end
        id_m[i] = id;
    endtask

    always @(posedge CLK) begin
        model_edge(0, 2, rst_a, ren_a, wen_a, addr_a, store_a);
        model_edge(1, 1, rst_b, ren_b, wen_b, addr_b, store_b);
    end

    // ---------------- per-cycle compare ----------------
    task automatic compare(input int i, input logic [1:0] st, input logic [31:0] ld);
        if (live_m[i]) begin
            vectors++;
            if (st !== st_m[i]) begin
                miscompares++;
                $display("FAIL ramstate[dut%0d] t=%0t: got %0d want %0d", i, $time, st, st_m[i]);
            end
            if (chk_m[i]) begin
                vectors++;
                if (ld !== ld_m[i]) begin
                    miscompares++;
                    $display("FAIL ramload[dut%0d] t=%0t: got 0x%08h want 0x%08h", i, $time, ld, ld_m[i]);
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        compare(0, state_a, load_a);
        compare(1, state_b, load_b);
    end

    // ---------------- literal expectations ----------------
    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s t=%0t: got 0x%08h want 0x%08h", name, $time, got, want);
        end
        $display("  %s t=%0t value 0x%08h", name, $time, got);
    endtask

    task automatic expect_a(input string name, input logic [1:0] st,
                            input bit chk_ld, input logic [31:0] ld);
        check_lit({name, ".state"}, {30'd0, state_a}, {30'd0, st});
        check_lit({name, ".model_state"}, {30'd0, st_m[0]}, {30'd0, st});
        if (chk_ld) begin
            check_lit({name, ".load"}, load_a, ld);
            check_lit({name, ".model_load"}, ld_m[0], ld);
        end
    endtask

    task automatic expect_b(input string name, input logic [1:0] st,
                            input bit chk_ld, input logic [31:0] ld);
        check_lit({name, ".state"}, {30'd0, state_b}, {30'd0, st});
        check_lit({name, ".model_state"}, {30'd0, st_m[1]}, {30'd0, st});
        if (chk_ld) begin
            check_lit({name, ".load"}, load_b, ld);
            check_lit({name, ".model_load"}, ld_m[1], ld);
        end
    endtask

    task automatic set_a(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] store);
        ren_a = ren; wen_a = wen; addr_a = addr; store_a = store;
    endtask

    task automatic set_b(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] store);
        ren_b = ren; wen_b = wen; addr_b = addr; store_b = store;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

    int          r_kind, r_hold;
    logic [31:0] r_addr, r_data;
    logic        r_wr;
    logic [31:0] sweep_d;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        tick(); tick();
        expect_a("reset_a", S_FREE, 1'b1, 32'h0);
        expect_b("reset_b", S_FREE, 1'b1, 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;

        // read of a cleared word
        set_a(1, 0, 32'h40, 0);
        tick(); expect_a("rd40_busy", S_BUSY, 1'b0, 0);
        tick(); expect_a("rd40_acc", S_ACC, 1'b1, 32'h0);
        set_a(0, 0, 0, 0); tick(); expect_a("rd40_free", S_FREE, 1'b0, 0);

        // write then read back
        set_a(0, 1, 32'h100, 32'hDEADBEEF);
        tick(); expect_a("wr100_busy", S_BUSY, 1'b0, 0);
        tick(); expect_a("wr100_acc", S_ACC, 1'b0, 0);
        set_a(0, 0, 0, 0); tick();
        set_a(1, 0, 32'h100, 0);
        tick(); expect_a("rd100_busy", S_BUSY, 1'b0, 0);
        tick(); expect_a("rd100_acc", S_ACC, 1'b1, 32'hDEADBEEF);
        tick(); expect_a("rd100_hold", S_ACC, 1'b1, 32'hDEADBEEF);
        set_a(0, 0, 0, 0); tick();

        // address change during BUSY restarts the count
        set_a(0, 1, 32'h204, 32'h12345678);
        tick(); tick(); set_a(0, 0, 0, 0); tick();
        set_a(1, 0, 32'h200, 0);
        tick(); expect_a("rd200_busy", S_BUSY, 1'b0, 0);
        addr_a = 32'h204;
        tick(); expect_a("rd204_restart", S_BUSY, 1'b0, 0);
        tick(); expect_a("rd204_acc", S_ACC, 1'b1, 32'h12345678);
        set_a(0, 0, 0, 0); tick();

        // aborted write leaves memory untouched
        set_a(0, 1, 32'h300, 32'hAAAA5555);
        tick(); expect_a("wr300_busy", S_BUSY, 1'b0, 0);
        set_a(0, 0, 0, 0); tick(); expect_a("wr300_abort", S_FREE, 1'b0, 0);
        set_a(1, 0, 32'h300, 0);
        tick(); tick(); expect_a("rd300_acc", S_ACC, 1'b1, 32'h0);
        set_a(0, 0, 0, 0); tick();

        // illegal requests
        set_a(1, 1, 32'h100, 32'h11111111);
        tick(); expect_a("both_err", S_ERR, 1'b0, 0);
        tick(); expect_a("both_err_hold", S_ERR, 1'b0, 0);
        set_a(0, 0, 0, 0); tick(); expect_a("both_free", S_FREE, 1'b0, 0);
        set_a(0, 1, 32'h102, 32'h22222222);
        tick(); expect_a("mis_err", S_ERR, 1'b0, 0);
        tick();
        set_a(0, 0, 0, 0); tick(); expect_a("mis_free", S_FREE, 1'b0, 0);
        set_a(0, 1, 32'h00010000, 32'h33333333);
        tick(); expect_a("oor_err", S_ERR, 1'b0, 0);
        set_a(0, 0, 0, 0); tick(); expect_a("oor_free", S_FREE, 1'b0, 0);
        set_a(1, 0, 32'h100, 0);
        tick(); tick(); expect_a("rd100_after_err", S_ACC, 1'b1, 32'hDEADBEEF);
        addr_a = 32'h0;
        tick(); expect_a("rd0_busy", S_BUSY, 1'b0, 0);
        tick(); expect_a("rd0_acc", S_ACC, 1'b1, 32'h0);
        set_a(0, 0, 0, 0); tick();

        // randomized traffic on the LAT=2 instance
        for (int n = 0; n < 300; n++) begin
            r_kind = $urandom_range(0, 9);
            r_addr = 32'($urandom_range(0, 15)) << 2;
            r_data = $urandom;
            r_wr   = ($urandom_range(0, 1) != 0);
            case (r_kind)
                0:       set_a(1'b0, 1'b1, r_addr | 32'h2, r_data);
                1:       set_a(1'b1, 1'b1, r_addr, r_data);
                2:       set_a(~r_wr, r_wr, r_addr | 32'h400, r_data);
                3:       set_a(1'b0, 1'b0, r_addr, r_data);
                default: set_a(~r_wr, r_wr, r_addr, r_data);
            endcase
            r_hold = $urandom_range(1, 4);
            for (int h = 0; h < r_hold; h++) begin
                tick();
                if ($urandom_range(0, 7) == 0) store_a = $urandom;
            end
            if ($urandom_range(0, 1) == 0) begin
                set_a(0, 0, 0, 0);
                tick();
            end
        end
        set_a(0, 0, 0, 0); tick();

        // LAT=1: back-to-back write/read over 64 words
        for (int i = 0; i < 64; i++) begin
            sweep_d = $urandom;
            set_b(0, 1, 32'(i) << 2, sweep_d);
            tick(); expect_b("sweep_wr", S_ACC, 1'b0, 0);
            set_b(1, 0, 32'(i) << 2, 0);
            tick(); expect_b("sweep_rd", S_ACC, 1'b1, sweep_d);
        end

        // reset on the edge that would commit a write
        set_b(0, 1, 32'h80, 32'hCAFEF00D);
        rst_b = 1'b1;
        tick(); expect_b("rst_mid_wr", S_FREE, 1'b1, 32'h0);
        rst_b = 1'b0;
        set_b(0, 0, 0, 0);
        tick(); expect_b("rst_after", S_FREE, 1'b0, 0);
        set_b(1, 0, 32'h80, 0);
        tick(); expect_b("rd80_after_rst", S_ACC, 1'b1, 32'h0);
        set_b(0, 0, 0, 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
